board_ram_writer: RTL and testbench
===================================

// Module: board_ram_writer
// PURPOSE
//  Write port of one 2-bit board RAM (us or them); dynamic_screen reads the same RAM on its read port.
//  Serves three commands from the game FSM: clear the board, place a ship (overlap/bounds checked), resolve a shot.
//  Read-modify-write through a synchronous RAM port (1-cycle read latency); keeps a count of unhit SHIP tiles.
// PARAMETERS
//  BOARD_DIM    10   tiles per side; legal coords 0..BOARD_DIM-1
//  ADDR_W       10   RAM address width; addr = {{(ADDR_W-8){1'b0}}, x[3:0], y[3:0]}
//  MAX_LEN      5    longest ship; legal place_len 2..MAX_LEN
//  CLEAR_WORDS  256  words written by a clear (all {x,y} codes)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset, asynchronous, active-low
//  clear_req    in   1       start board clear (sampled only in IDLE)
//  place_req    in   1       start ship placement (sampled only in IDLE)
//  place_x/y    in   4 each  bow tile coords
//  place_len    in   3       ship length
//  place_vert   in   1       1: ship extends +y, 0: ship extends +x
//  shot_req     in   1       start shot resolution (sampled only in IDLE)
//  shot_x/y     in   4 each  target tile
//  ram_addr     out  ADDR_W  RAM address (read and write)
//  ram_we       out  1       RAM write enable
//  ram_wdata    out  2       tile code written
//  ram_rdata    in   2       tile code read; valid one cycle after ram_addr
//  busy         out  1       high from accept until the cycle done is asserted
//  done         out  1       one-cycle pulse; result valid in the same cycle
//  result       out  2       OK=0 MISS=1 HIT=2 REJECT=3
//  ships_left   out  5       remaining SHIP tiles
//  all_sunk     out  1       ships_left==0 && at least one placement accepted since the last clear
// BEHAVIOUR
//  Tile codes: EMPTY=0 MISS=1 HIT=2 SHIP=3. All outputs are registered.
//  Reset (rst=0, async): state IDLE; outputs 0, ram_addr 0; ships_left 0; placed flag 0. RAM is not cleared; the game FSM issues a clear.
//  IDLE: priority clear > place > shot when requests coincide. Requests seen while busy are dropped, not queued.
//  CLEAR: ram_we=1, wdata=EMPTY, addr 0..CLEAR_WORDS-1, one per cycle (256 cycles).
//    Then DONE with result=OK; ships_left<=0, placed<=0.
//  PLACE (accept cycle): reject when place_len<2 or >MAX_LEN, or coord >BOARD_DIM-1,
//    or bow+len-1 >BOARD_DIM-1 on the growth axis; reject goes straight to DONE (REJECT, no RAM access).
//  P_CHECK: issue len reads on consecutive cycles and compare ram_rdata one cycle later;
//    any non-EMPTY tile gives REJECT with zero writes.
//    Takes len+1 cycles.
//  P_WRITE: len cycles of ram_we=1, wdata=SHIP, same tile order.
//    Then ships_left+=len, saturating at 31; placed<=1; result OK.
//  SHOT: reject out-of-range coords (REJECT). S_READ issues the address; S_WAIT captures rdata; then:
//    SHIP  -> write HIT, result HIT, ships_left-=1 (floor 0)
//    EMPTY -> write MISS, result MISS
//    HIT/MISS -> no write, result REJECT (repeat shot).
//  DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE. A new request is accepted the cycle after DONE.
//  Latency, accept to done: clear 257; legal place 2*len+2; legal shot 4; rejected command 1.
//  ram_we is never high outside CLEAR, P_WRITE and the shot write cycle.
// CONFIGURATION
//  BOARD_WRITER_STATS_EN defined: adds outputs shots_fired[6:0] and hits_scored[6:0].
//    shots_fired counts non-REJECT shots; hits_scored counts HIT results.
//    Both saturate at 127 and are zeroed by reset and by clear.
//  Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package battleship_pkg: tile codes, result codes, BOARD_DIM, MAX_LEN, address-pack function {x,y}.
//    dynamic_screen uses the same tile codes.
//  Single FSM plus a tile stepper (x or y +1 per cycle) and a 5-bit len counter.
//  No sub-module; the bounds check is a combinational function in the package.
// TESTING
//  Clear after reset -> 256 writes of 0, addr 0..255; done at cycle 257 with result 0; ships_left 0.
//  Place (2,3) len 5 horizontal -> SHIP at x=2..6, y=3 (addrs 0x23,0x33..0x63); done after 12 cycles; ships_left 5.
//  Place (5,1) len 3 vertical over the ship above -> REJECT, zero ram_we cycles, ships_left still 5.
//  Place (8,0) len 3 horizontal -> REJECT in 1 cycle, no RAM access.
//  Shot (4,3) -> HIT, tile becomes 2, ships_left 4. Repeat shot -> REJECT, no write. Shot (0,0) -> MISS, tile 1.
//  Reset asserted mid-P_WRITE -> outputs 0 at once; after release, busy 0; clear_req accepted next cycle.
//  STATS_EN: 2 shots + 1 repeat -> shots_fired 2, hits_scored 1; clear zeroes both.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared board definitions: tile codes, result codes, board geometry,
// address packing and the placement bounds check.
package battleship_pkg;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_MISS  = 2'd1,
        TILE_HIT   = 2'd2,
        TILE_SHIP  = 2'd3
    } tile_e;

    typedef enum logic [1:0] {
        RES_OK     = 2'd0,
        RES_MISS   = 2'd1,
        RES_HIT    = 2'd2,
        RES_REJECT = 2'd3
    } result_e;

    localparam int BOARD_DIM   = 10;
    localparam int MAX_LEN     = 5;
    localparam int CLEAR_WORDS = 256;

    function automatic logic [7:0] pack_addr(input logic [3:0] x,
                                             input logic [3:0] y);
        return {x, y};
    endfunction

    function automatic logic coord_ok(input logic [3:0] c);
        return c <= 4'(BOARD_DIM - 1);
    endfunction

    function automatic logic place_ok(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic [2:0] len,
                                      input logic       vert);
        logic [4:0] tail;
        tail = (vert ? {1'b0, y} : {1'b0, x}) + {2'b00, len} - 5'd1;
        return (len >= 3'd2) && (len <= 3'(MAX_LEN)) &&
               coord_ok(x) && coord_ok(y) &&
               (tail <= 5'(BOARD_DIM - 1));
    endfunction

endpackage

// File: rtl/board_ram_writer.sv
// Board RAM write port: clear, ship placement and shot resolution.
// Optional BOARD_WRITER_STATS_EN adds shots_fired / hits_scored counters.
module board_ram_writer
    import battleship_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              place_req,
    input  logic [3:0]        place_x,
    input  logic [3:0]        place_y,
    input  logic [2:0]        place_len,
    input  logic              place_vert,
    input  logic              shot_req,
    input  logic [3:0]        shot_x,
    input  logic [3:0]        shot_y,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result,
    output logic [4:0]        ships_left,
`ifdef BOARD_WRITER_STATS_EN
    output logic [6:0]        shots_fired,
    output logic [6:0]        hits_scored,
`endif
    output logic              all_sunk
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PCHECK, S_PWRITE,
        S_SREAD, S_SWAIT, S_SWRITE, S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [1:0] wdata_q, wdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] result_q, result_d;
    logic [1:0] pend_q, pend_d;
    logic [4:0] ships_q, ships_d;
    logic       placed_q, placed_d;
    logic       sunk_q, sunk_d;
    logic [3:0] bx_q, bx_d, by_q, by_d;
    logic [3:0] cx_q, cx_d, cy_q, cy_d;
    logic [2:0] len_q, len_d;
    logic       vert_q, vert_d;
    logic [4:0] cnt_q, cnt_d;
    logic       bad_q, bad_d;
    logic       bad_now;
    logic [5:0] sum6;
`ifdef BOARD_WRITER_STATS_EN
    logic [6:0] shots_q, shots_d, hits_q, hits_d;
`endif

    assign ram_addr   = {{(ADDR_W-8){1'b0}}, addr_q};
    assign ram_we     = we_q;
    assign ram_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign ships_left = ships_q;
    assign all_sunk   = sunk_q;
`ifdef BOARD_WRITER_STATS_EN
    assign shots_fired = shots_q;
    assign hits_scored = hits_q;
`endif

    assign sum6 = {1'b0, ships_q} + {3'b000, len_q};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        result_d = result_q;
        pend_d   = pend_q;
        ships_d  = ships_q;
        placed_d = placed_q;
        bx_d     = bx_q;
        by_d     = by_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        len_d    = len_q;
        vert_d   = vert_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        bad_now  = 1'b0;
`ifdef BOARD_WRITER_STATS_EN
        shots_d  = shots_q;
        hits_d   = hits_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    addr_d  = 8'd0;
                    we_d    = 1'b1;
                    wdata_d = TILE_EMPTY;
                end else if (place_req) begin
                    if (!place_ok(place_x, place_y, place_len, place_vert)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = RES_REJECT;
                    end else begin
                        state_d = S_PCHECK;
                        bx_d    = place_x;
                        by_d    = place_y;
                        len_d   = place_len;
                        vert_d  = place_vert;
                        addr_d  = pack_addr(place_x, place_y);
                        cx_d    = place_vert ? place_x : place_x + 4'd1;
                        cy_d    = place_vert ? place_y + 4'd1 : place_y;
                        cnt_d   = {2'b00, place_len};
                        bad_d   = 1'b0;
                    end
                end else if (shot_req) begin
                    if (!(coord_ok(shot_x) && coord_ok(shot_y))) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = RES_REJECT;
                    end else begin
                        state_d = S_SREAD;
                        addr_d  = pack_addr(shot_x, shot_y);
                    end
                end
            end
            S_CLEAR: begin
                if (addr_q == 8'(CLEAR_WORDS - 1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_OK;
                    ships_d  = 5'd0;
                    placed_d = 1'b0;
`ifdef BOARD_WRITER_STATS_EN
                    shots_d  = 7'd0;
                    hits_d   = 7'd0;
`endif
                end else begin
                    addr_d = addr_q + 8'd1;
                    we_d   = 1'b1;
                end
            end
            S_PCHECK: begin
                // First cycle only presents the bow address; data lags by one.
                bad_now = (cnt_q != {2'b00, len_q}) && (ram_rdata != TILE_EMPTY);
                bad_d   = bad_q | bad_now;
                if (cnt_q >= 5'd2) begin
                    addr_d = pack_addr(cx_q, cy_q);
                    cx_d   = vert_q ? cx_q : cx_q + 4'd1;
                    cy_d   = vert_q ? cy_q + 4'd1 : cy_q;
                end
                if (cnt_q == 5'd0) begin
                    if (bad_q | bad_now) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = RES_REJECT;
                    end else begin
                        state_d = S_PWRITE;
                        addr_d  = pack_addr(bx_q, by_q);
                        we_d    = 1'b1;
                        wdata_d = TILE_SHIP;
                        cx_d    = vert_q ? bx_q : bx_q + 4'd1;
                        cy_d    = vert_q ? by_q + 4'd1 : by_q;
                        cnt_d   = {2'b00, len_q} - 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_PWRITE: begin
                if (cnt_q != 5'd0) begin
                    addr_d = pack_addr(cx_q, cy_q);
                    cx_d   = vert_q ? cx_q : cx_q + 4'd1;
                    cy_d   = vert_q ? cy_q + 4'd1 : cy_q;
                    we_d   = 1'b1;
                    cnt_d  = cnt_q - 5'd1;
                end else begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_OK;
                    ships_d  = (sum6 > 6'd31) ? 5'd31 : sum6[4:0];
                    placed_d = 1'b1;
                end
            end
            S_SREAD: state_d = S_SWAIT;
            S_SWAIT: begin
                state_d = S_SWRITE;
                unique case (ram_rdata)
                    TILE_SHIP: begin
                        we_d    = 1'b1;
                        wdata_d = TILE_HIT;
                        pend_d  = RES_HIT;
                    end
                    TILE_EMPTY: begin
                        we_d    = 1'b1;
                        wdata_d = TILE_MISS;
                        pend_d  = RES_MISS;
                    end
                    default: pend_d = RES_REJECT;
                endcase
            end
            S_SWRITE: begin
                state_d  = S_DONE;
                done_d   = 1'b1;
                result_d = pend_q;
                if (pend_q == RES_HIT && ships_q != 5'd0) begin
                    ships_d = ships_q - 5'd1;
                end
`ifdef BOARD_WRITER_STATS_EN
                if (pend_q != RES_REJECT && shots_q != 7'd127) begin
                    shots_d = shots_q + 7'd1;
                end
                if (pend_q == RES_HIT && hits_q != 7'd127) begin
                    hits_d = hits_q + 7'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        sunk_d = (ships_d == 5'd0) && placed_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 8'd0;
            we_q     <= 1'b0;
            wdata_q  <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 2'd0;
            pend_q   <= 2'd0;
            ships_q  <= 5'd0;
            placed_q <= 1'b0;
            sunk_q   <= 1'b0;
            bx_q     <= 4'd0;
            by_q     <= 4'd0;
            cx_q     <= 4'd0;
            cy_q     <= 4'd0;
            len_q    <= 3'd0;
            vert_q   <= 1'b0;
            cnt_q    <= 5'd0;
            bad_q    <= 1'b0;
`ifdef BOARD_WRITER_STATS_EN
            shots_q  <= 7'd0;
            hits_q   <= 7'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            pend_q   <= pend_d;
            ships_q  <= ships_d;
            placed_q <= placed_d;
            sunk_q   <= sunk_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            len_q    <= len_d;
            vert_q   <= vert_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
`ifdef BOARD_WRITER_STATS_EN
            shots_q  <= shots_d;
            hits_q   <= hits_d;
`endif
        end
    end

endmodule

// File: tb/tb_board_ram_writer.sv
// Scoreboard bench for board_ram_writer with a behavioural 1-cycle RAM
// and a board model that predicts results, writes and ship counts.
module tb_board_ram_writer;
    import battleship_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req, place_req, shot_req;
    logic [3:0] place_x, place_y, shot_x, shot_y;
    logic [2:0] place_len;
    logic       place_vert;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata, ram_rdata;
    logic       busy, done;
    logic [1:0] result;
    logic [4:0] ships_left;
    logic       all_sunk;
`ifdef BOARD_WRITER_STATS_EN
    logic [6:0] shots_fired, hits_scored;
`endif

    board_ram_writer #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .clear_req(clear_req), .place_req(place_req),
        .place_x(place_x), .place_y(place_y),
        .place_len(place_len), .place_vert(place_vert),
        .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .done(done), .result(result),
        .ships_left(ships_left),
`ifdef BOARD_WRITER_STATS_EN
        .shots_fired(shots_fired), .hits_scored(hits_scored),
`endif
        .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    logic [9:0] wa_q[$];
    logic [1:0] wd_q[$];
    always @(negedge clk) begin
        if (ram_we) begin
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
        end
    end

    typedef struct { logic [1:0] res; int lat; } exp_t;
    typedef struct { int x; int y; int len; bit vert; } pl_t;
    typedef struct { int x; int y; } sh_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] bm [0:15][0:15];
    int         exp_ships = 0;
    bit         exp_placed = 0;
    int         exp_shots = 0;
    int         exp_hits = 0;

    task automatic model_clear();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) bm[x][y] = TILE_EMPTY;
        exp_ships = 0; exp_placed = 0; exp_shots = 0; exp_hits = 0;
    endtask

    task automatic do_cmd(input int kind, input int x, input int y,
                          input int len, input bit vert,
                          output logic [1:0] res, output int lat,
                          output logic [4:0] sh, output logic sk);
        @(negedge clk);
        if (kind == 0) clear_req = 1'b1;
        else if (kind == 1) begin
            place_x = 4'(x); place_y = 4'(y);
            place_len = 3'(len); place_vert = vert; place_req = 1'b1;
        end else begin
            shot_x = 4'(x); shot_y = 4'(y); shot_req = 1'b1;
        end
        @(posedge clk); #1;
        clear_req = 1'b0; place_req = 1'b0; shot_req = 1'b0;
        lat = -1; res = 2'd0; sh = 5'd0; sk = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n; res = result; sh = ships_left; sk = all_sunk;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_req = 0; place_req = 0; shot_req = 0;
        place_x = 0; place_y = 0; place_len = 0; place_vert = 0;
        shot_x = 0; shot_y = 0;
        #12;
        total++;
        if ({ram_addr, ram_we, busy, done, result, ships_left, all_sunk} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {ram_addr, ram_we, busy, done, result, ships_left, all_sunk});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_clear();
        logic [1:0] res; int lat; logic [4:0] sh; logic sk;
        int base; exp_t e; int errs;
        base = wa_q.size();
        sb.push_back('{RES_OK, 257});
        do_cmd(0, 0, 0, 0, 0, res, lat, sh, sk);
        e = sb.pop_front();
        model_clear();
        total++;
        if (res !== e.res) begin bad++; $display("FAIL clear_result got=%0d want=%0d", res, e.res); end
        total++;
        if (lat != e.lat) begin bad++; $display("FAIL clear_latency got=%0d want=%0d", lat, e.lat); end
        total++;
        if ({sh, sk} !== 6'd0) begin bad++; $display("FAIL clear_ships got=%0d/%b want=0/0", sh, sk); end
        total++;
        if (wa_q.size() - base != 256) begin
            bad++; $display("FAIL clear_writes got=%0d want=256", wa_q.size() - base);
        end else begin
            errs = 0;
            for (int i = 0; i < 256; i++)
                if (wa_q[base+i] !== 10'(i) || wd_q[base+i] !== 2'd0) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL clear_order got=%0d bad words want=0", errs); end
        end
    endtask

    task automatic test_place(input pl_t rows[$]);
        logic [1:0] res; int lat; logic [4:0] sh; logic sk;
        int base; exp_t e; bit legal, ovl; int tx, ty, ew, errs;
        foreach (rows[i]) begin
            legal = rows[i].len >= 2 && rows[i].len <= 5 && rows[i].x <= 9 && rows[i].y <= 9 &&
                    ((rows[i].vert ? rows[i].y : rows[i].x) + rows[i].len - 1) <= 9;
            ovl = 0;
            if (legal)
                for (int k = 0; k < rows[i].len; k++) begin
                    tx = rows[i].vert ? rows[i].x : rows[i].x + k;
                    ty = rows[i].vert ? rows[i].y + k : rows[i].y;
                    if (bm[tx][ty] != TILE_EMPTY) ovl = 1;
                end
            if (!legal) sb.push_back('{RES_REJECT, 1});
            else if (ovl) sb.push_back('{RES_REJECT, -1});
            else sb.push_back('{RES_OK, 2*rows[i].len + 2});
            ew = (legal && !ovl) ? rows[i].len : 0;
            if (ew != 0) begin
                exp_ships = (exp_ships + ew > 31) ? 31 : exp_ships + ew;
                exp_placed = 1;
            end
            base = wa_q.size();
            do_cmd(1, rows[i].x, rows[i].y, rows[i].len, rows[i].vert, res, lat, sh, sk);
            e = sb.pop_front();
            total++;
            if (res !== e.res) begin bad++; $display("FAIL place%0d_result got=%0d want=%0d", i, res, e.res); end
            total++;
            if (e.lat < 0 ? lat <= 0 : lat != e.lat) begin
                bad++; $display("FAIL place%0d_latency got=%0d want=%0d", i, lat, e.lat);
            end
            total++;
            if (sh !== 5'(exp_ships) || sk !== (exp_placed && exp_ships == 0)) begin
                bad++; $display("FAIL place%0d_ships got=%0d/%b want=%0d", i, sh, sk, exp_ships);
            end
            total++;
            if (wa_q.size() - base != ew) begin
                bad++; $display("FAIL place%0d_writes got=%0d want=%0d", i, wa_q.size() - base, ew);
            end else if (ew != 0) begin
                errs = 0;
                for (int k = 0; k < ew; k++) begin
                    tx = rows[i].vert ? rows[i].x : rows[i].x + k;
                    ty = rows[i].vert ? rows[i].y + k : rows[i].y;
                    if (wa_q[base+k] !== {2'b00, 4'(tx), 4'(ty)} || wd_q[base+k] !== TILE_SHIP) errs++;
                    bm[tx][ty] = TILE_SHIP;
                end
                total++;
                if (errs != 0) begin bad++; $display("FAIL place%0d_tiles got=%0d bad want=0", i, errs); end
            end
        end
    endtask

    task automatic test_shot(input sh_t rows[$]);
        logic [1:0] res; int lat; logic [4:0] sh; logic sk;
        int base; exp_t e; bit inr; logic [1:0] t, nt;
        foreach (rows[i]) begin
            inr = rows[i].x <= 9 && rows[i].y <= 9;
            t = inr ? bm[rows[i].x][rows[i].y] : TILE_EMPTY;
            if (!inr) sb.push_back('{RES_REJECT, 1});
            else if (t == TILE_SHIP) sb.push_back('{RES_HIT, 4});
            else if (t == TILE_EMPTY) sb.push_back('{RES_MISS, 4});
            else sb.push_back('{RES_REJECT, 4});
            base = wa_q.size();
            do_cmd(2, rows[i].x, rows[i].y, 0, 0, res, lat, sh, sk);
            e = sb.pop_front();
            if (e.res == RES_HIT) begin
                if (exp_ships > 0) exp_ships--;
                if (exp_hits < 127) exp_hits++;
            end
            if (e.res != RES_REJECT && exp_shots < 127) exp_shots++;
            nt = (e.res == RES_HIT) ? TILE_HIT : TILE_MISS;
            total++;
            if (res !== e.res) begin bad++; $display("FAIL shot%0d_result got=%0d want=%0d", i, res, e.res); end
            total++;
            if (lat != e.lat) begin bad++; $display("FAIL shot%0d_latency got=%0d want=%0d", i, lat, e.lat); end
            total++;
            if (sh !== 5'(exp_ships) || sk !== (exp_placed && exp_ships == 0)) begin
                bad++; $display("FAIL shot%0d_ships got=%0d/%b want=%0d", i, sh, sk, exp_ships);
            end
            total++;
            if (e.res == RES_HIT || e.res == RES_MISS) begin
                if (wa_q.size() - base != 1 || wa_q[base] !== {2'b00, 4'(rows[i].x), 4'(rows[i].y)} ||
                    wd_q[base] !== nt) begin
                    bad++; $display("FAIL shot%0d_write got=%0d writes want=1 of %0d", i, wa_q.size() - base, nt);
                end
                bm[rows[i].x][rows[i].y] = nt;
            end else if (wa_q.size() != base) begin
                bad++; $display("FAIL shot%0d_nowrite got=%0d writes want=0", i, wa_q.size() - base);
            end
        end
    endtask

    task automatic test_sink();
        sh_t tgt[$];
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
                if (bm[x][y] == TILE_SHIP) tgt.push_back('{x, y});
        test_shot(tgt);
        total++;
        if (ships_left !== 5'd0 || all_sunk !== 1'b1) begin
            bad++; $display("FAIL sink_all got=%0d/%b want=0/1", ships_left, all_sunk);
        end
    endtask

    task automatic test_busy_drop();
        logic [1:0] res; int lat; logic [4:0] sh; logic sk;
        int base; exp_t e; int err;
        base = wa_q.size();
        sb.push_back('{RES_OK, 257});
        fork
            do_cmd(0, 0, 0, 0, 0, res, lat, sh, sk);
            begin
                repeat (10) @(negedge clk);
                shot_x = 4'd1; shot_y = 4'd1; shot_req = 1'b1;
                place_x = 4'd0; place_y = 4'd0; place_len = 3'd2; place_req = 1'b1;
                repeat (3) @(negedge clk);
                shot_req = 1'b0; place_req = 1'b0;
            end
        join
        e = sb.pop_front();
        model_clear();
        total++;
        if (res !== e.res || lat != e.lat) begin
            bad++; $display("FAIL busy_clear got=%0d/%0d want=%0d/%0d", res, lat, e.res, e.lat);
        end
        total++;
        if (sh !== 5'd0 || sk !== 1'b0) begin
            bad++; $display("FAIL busy_sunk_cleared got=%0d/%b want=0/0", sh, sk);
        end
        err = 0;
        repeat (3) begin @(negedge clk); if (busy !== 1'b0 || ram_we !== 1'b0) err++; end
        total++;
        if (err != 0 || wa_q.size() - base != 256) begin
            bad++; $display("FAIL busy_dropped got=%0d writes %0d busy want=256 0", wa_q.size() - base, err);
        end
    endtask

    task automatic test_reset_mid_write();
        int n; exp_t e;
        @(negedge clk);
        place_x = 4'd1; place_y = 4'd1; place_len = 3'd4; place_vert = 1'b0; place_req = 1'b1;
        @(posedge clk); #1; place_req = 1'b0;
        n = 0;
        while (ram_we !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        total++;
        if (ram_we !== 1'b1) begin bad++; $display("FAIL rstmid_reach got=%b want=1", ram_we); end
        #2 rst = 1'b0; #1;
        total++;
        if ({ram_addr, ram_we, busy, done, result, ships_left, all_sunk} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%h want=0",
                            {ram_addr, ram_we, busy, done, result, ships_left, all_sunk});
        end
        @(negedge clk); rst = 1'b1; clear_req = 1'b1; #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        sb.push_back('{RES_OK, 257});
        @(posedge clk); #1; clear_req = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", busy); end
        n = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin n = k; break; end
        end
        e = sb.pop_front();
        model_clear();
        total++;
        if (n != e.lat || result !== e.res) begin
            bad++; $display("FAIL rstmid_clear got=%0d/%0d want=%0d/%0d", n, result, e.lat, e.res);
        end
    endtask

`ifdef BOARD_WRITER_STATS_EN
    task automatic test_stats();
        pl_t p[$];
        sh_t s[$];
        total++;
        if (shots_fired !== 7'd0 || hits_scored !== 7'd0) begin
            bad++; $display("FAIL stats_init got=%0d/%0d want=0/0", shots_fired, hits_scored);
        end
        p = '{'{0, 0, 2, 0}};
        test_place(p);
        s = '{'{0, 0}, '{5, 5}, '{0, 0}};
        test_shot(s);
        total++;
        if (shots_fired !== 7'(exp_shots) || hits_scored !== 7'(exp_hits)) begin
            bad++; $display("FAIL stats_count got=%0d/%0d want=%0d/%0d",
                            shots_fired, hits_scored, exp_shots, exp_hits);
        end
        test_clear();
        total++;
        if (shots_fired !== 7'd0 || hits_scored !== 7'd0) begin
            bad++; $display("FAIL stats_clear got=%0d/%0d want=0/0", shots_fired, hits_scored);
        end
    endtask
`endif

    initial begin
        pl_t ptab[$];
        sh_t stab[$];
        ptab = '{'{2, 3, 5, 0}, '{9, 8, 2, 1}, '{5, 1, 3, 1}, '{8, 0, 3, 0},
                 '{0, 0, 1, 0}, '{0, 0, 6, 0}, '{10, 0, 2, 1}, '{0, 9, 2, 1},
                 '{5, 5, 5, 1}};
        stab = '{'{4, 3}, '{4, 3}, '{0, 0}, '{10, 0}, '{0, 12}, '{9, 9}};
        model_clear();
        test_reset();
        test_clear();
        test_place(ptab);
        test_shot(stab);
        test_sink();
        test_busy_drop();
        test_reset_mid_write();
`ifdef BOARD_WRITER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
